// File: rtl/sram_sample_streamer.sv
// Streams SRAM words [start_addr..end_addr] into a sample FIFO (SRAM_STREAM_CE_GATE_EN: deselect chip when not reading).
// Latency start->first sample_valid WAIT_CYCLES+2; a full FIFO parks the reader in HOLD until sample_ready frees a slot.
module sram_sample_streamer #(
   parameter int ADDR_W      = 20,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   input  logic [DATA_W-1:0] SRAM_DQ_IN,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic              SRAM_CE_N,
   output logic              SRAM_UB_N,
   output logic              SRAM_LB_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_WE_N,
   output logic [DATA_W-1:0] sample_out,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              busy,
   output logic              done
);

   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CW  = PW + 1;
   localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_HOLD, S_DONE
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_q, start_q, end_q;
   logic              loop_q, stop_q;
   logic [WCW-1:0]    wait_cnt;
   logic              oe_n, push, stop_hit, slot_free;

   logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     fifo_count;
   logic              pop;

   assign sample_valid = (fifo_count != '0);
   assign sample_out   = sample_valid ? fifo_mem[rd_ptr] : '0;
   assign pop          = sample_valid && sample_ready;
   // A word leaving this cycle makes room for the word about to be read.
   assign slot_free    = (fifo_count != CW'(FIFO_DEPTH)) || pop;
   assign stop_hit     = stop || stop_q;

   always_comb begin
      state_nxt = state;
      oe_n      = 1'b1;
      push      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = (start_addr <= end_addr) ? S_ISSUE : S_DONE;
         end
         S_ISSUE: begin
            if (slot_free) begin
               oe_n      = 1'b0;
               state_nxt = (WAIT_CYCLES == 1) ? S_CAPTURE : S_WAIT;
            end else begin
               state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (slot_free) state_nxt = S_ISSUE;
         end
         S_WAIT: begin
            oe_n = 1'b0;
            if (wait_cnt <= WCW'(1)) state_nxt = S_CAPTURE;
         end
         S_CAPTURE: begin
            oe_n = 1'b0;
            push = 1'b1;
            if (stop_hit || (addr_q == end_q && !loop_q)) state_nxt = S_DONE;
            else                                          state_nxt = S_ISSUE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         state    <= S_IDLE;
         addr_q   <= '0;
         start_q  <= '0;
         end_q    <= '0;
         loop_q   <= 1'b0;
         stop_q   <= 1'b0;
         wait_cnt <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (start && start_addr <= end_addr) begin
                  addr_q  <= start_addr;
                  start_q <= start_addr;
                  end_q   <= end_addr;
                  loop_q  <= loop_en;
               end
            end
            S_ISSUE: wait_cnt <= WCW'(WAIT_CYCLES - 1);
            S_WAIT:  wait_cnt <= wait_cnt - 1'b1;
            S_CAPTURE: begin
               // Last address is kept (never incremented), so the top of the space cannot wrap to 0.
               if (state_nxt == S_ISSUE)
                  addr_q <= (addr_q == end_q) ? start_q : addr_q + 1'b1;
            end
            default: ;
         endcase
         if (state == S_IDLE || state == S_DONE) stop_q <= 1'b0;
         else if (stop)                          stop_q <= 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (push) fifo_mem[wr_ptr] <= SRAM_DQ_IN;
   end

   assign SRAM_ADDR = addr_q;
   assign SRAM_OE_N = oe_n;
   assign SRAM_WE_N = 1'b1;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign busy      = (state == S_ISSUE) || (state == S_WAIT) ||
                      (state == S_CAPTURE) || (state == S_HOLD);
   assign done      = (state == S_DONE);

`ifdef SRAM_STREAM_CE_GATE_EN
   assign SRAM_CE_N = !((state == S_ISSUE) || (state == S_WAIT) || (state == S_CAPTURE));
`else
   assign SRAM_CE_N = 1'b0;
`endif

endmodule

// File: tb/tb_sram_sample_streamer.sv
// Randomised bench for sram_sample_streamer: SRAM holds mem[a] = a*3, expected samples follow the address sequence.
module tb_sram_sample_streamer;
   localparam int ADDR_W      = 20;
   localparam int DATA_W      = 16;
   localparam int WAIT_CYCLES = 2;
   localparam int FIFO_DEPTH  = 4;
`ifdef SRAM_STREAM_CE_GATE_EN
   localparam logic CE_IDLE = 1'b1;
`else
   localparam logic CE_IDLE = 1'b0;
`endif

   logic              Clk = 1'b0;
   logic              reset, start, stop, loop_en, sample_ready;
   logic [ADDR_W-1:0] start_addr, end_addr, SRAM_ADDR;
   logic [DATA_W-1:0] SRAM_DQ_IN, sample_out;
   logic              SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N;
   logic              sample_valid, busy, done;

   int   n_cmp = 0, n_err = 0;
   int   n_done = 0, n_got = 0, n_oe_low = 0, rdy_mode = 1;
   logic addr_zero_seen = 1'b0;
   logic [ADDR_W-1:0] m_start, m_end, m_next;
   logic              m_loop;

   sram_sample_streamer dut (
      .Clk(Clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
      .start_addr(start_addr), .end_addr(end_addr), .SRAM_DQ_IN(SRAM_DQ_IN),
      .SRAM_ADDR(SRAM_ADDR), .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N),
      .SRAM_LB_N(SRAM_LB_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
      .sample_out(sample_out), .sample_valid(sample_valid), .sample_ready(sample_ready),
      .busy(busy), .done(done)
   );

   always #5 Clk = ~Clk;

   function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
      logic [31:0] p;
      p = 32'(a) * 32'd3;
      return p[DATA_W-1:0];
   endfunction

   // Data bus only carries the word while the SRAM output is enabled.
   assign SRAM_DQ_IN = SRAM_OE_N ? DATA_W'(16'hDEAD) : mem_val(SRAM_ADDR);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_model(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ea, input logic lp);
      m_start = sa; m_end = ea; m_loop = lp; m_next = sa; n_got = 0;
   endtask

   // One clock: observe at the falling edge, then drive sample_ready just after the rising edge.
   task automatic step();
      @(negedge Clk);
      if (!reset) begin
         if (done) begin
            n_done++;
            check("busy_at_done", busy, 0);
         end
         if (!SRAM_OE_N) n_oe_low++;
         if (SRAM_ADDR == '0) addr_zero_seen = 1'b1;
         check("ctl_pins", {SRAM_WE_N, SRAM_UB_N, SRAM_LB_N}, 3'b100);
`ifdef SRAM_STREAM_CE_GATE_EN
         if (!busy) check("ce_idle", SRAM_CE_N, 1);
         if (!SRAM_OE_N) check("ce_read", SRAM_CE_N, 0);
`else
         check("ce_n", SRAM_CE_N, 0);
`endif
         if (sample_valid && sample_ready) begin
            check("sample", sample_out, mem_val(m_next));
            m_next = (m_next == m_end && m_loop) ? m_start : m_next + 1'b1;
            n_got++;
         end
      end
      @(posedge Clk);
      #1;
      if (rdy_mode == 2) sample_ready = ($urandom_range(0, 3) != 0);
      else               sample_ready = (rdy_mode == 1);
   endtask

   task automatic kick(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ea, input logic lp);
      start_addr = sa; end_addr = ea; loop_en = lp; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int d, k;
      d = n_done; k = 0;
      while (n_done == d && k < budget) begin step(); k++; end
      check("done_seen", n_done - d, 1);
   endtask

   task automatic drain();
      int k;
      rdy_mode = 1; k = 0;
      while (sample_valid && k < 64) begin step(); k++; end
      step();
      check("drained", sample_valid, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_addr"}, SRAM_ADDR, 0);
      check({tag, "_oe"}, SRAM_OE_N, 1);
      check({tag, "_ce"}, SRAM_CE_N, CE_IDLE);
      check({tag, "_valid"}, sample_valid, 0);
      check({tag, "_out"}, sample_out, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat, d0, o0, g0, g1, len, k;
      logic [ADDR_W-1:0] sa;
      reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
      start_addr = '0; end_addr = '0; sample_ready = 1'b1;
      set_model('0, '0, 1'b0);
      repeat (3) step();
      reset = 1'b0;
      check_reset_outputs("rst");

      // Plain range, no back-pressure
      set_model(20'h10, 20'h13, 1'b0);
      rdy_mode = 1; step();
      d0 = n_done;
      kick(20'h10, 20'h13, 1'b0);
      lat = 1;
      while (!sample_valid && lat < 20) begin step(); lat++; end
      check("first_latency", lat, WAIT_CYCLES + 2);
      wait_done(40);
      drain();
      o0 = n_oe_low;
      repeat (10) step();
      check("no_oe_after_done", n_oe_low - o0, 0);
      check("plain_count", n_got, 4);
      check("plain_done_once", n_done - d0, 1);

      // Back-pressure: FIFO fills, reader parks with the next address held
      set_model(20'h00, 20'h09, 1'b0);
      rdy_mode = 0; step();
      kick(20'h00, 20'h09, 1'b0);
      repeat (30) step();
      check("bp_oe_hold", SRAM_OE_N, 1);
      check("bp_busy", busy, 1);
      check("bp_valid", sample_valid, 1);
      check("bp_addr_held", SRAM_ADDR, 4);
      check("bp_nothing_taken", n_got, 0);
`ifdef SRAM_STREAM_CE_GATE_EN
      check("bp_ce_hold", SRAM_CE_N, 1);
`endif
      rdy_mode = 1;
      wait_done(200);
      drain();
      check("bp_count", n_got, 10);

      // Looping playback, then stop during a read
      set_model(20'h20, 20'h21, 1'b1);
      rdy_mode = 2;
      kick(20'h20, 20'h21, 1'b1);
      repeat (40) step();
      rdy_mode = 0;
      repeat (30) step();
      check("loop_hold_oe", SRAM_OE_N, 1);
      check("loop_busy", busy, 1);
      check("loop_wrapped", n_got > 2, 1);
      g0 = n_got;
      rdy_mode = 1; step();
      rdy_mode = 0; step();
      check("loop_reissue_oe", SRAM_OE_N, 0);
      step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      wait_done(20);
      check("stop_busy", busy, 0);
      check("stop_fifo_held", sample_valid, 1);
      g1 = n_got;
      check("stop_one_popped", g1 - g0, 1);
      drain();
      check("stop_pending", n_got - g1, FIFO_DEPTH);

      // Reversed range: immediate done, no read
      o0 = n_oe_low; d0 = n_done;
      kick(20'h05, 20'h04, 1'b0);
      check("rev_done", done, 1);
      check("rev_busy", busy, 0);
      step();
      check("rev_done_pulse", done, 0);
      check("rev_done_count", n_done - d0, 1);
      check("rev_no_oe", n_oe_low - o0, 0);
      check("rev_no_valid", sample_valid, 0);

      // start while busy is ignored
      set_model(20'h40, 20'h43, 1'b0);
      rdy_mode = 2; d0 = n_done;
      kick(20'h40, 20'h43, 1'b0);
      step(); step();
      check("busy_before_restart", busy, 1);
      kick(20'h100, 20'h105, 1'b0);
      wait_done(100);
      drain();
      check("ignored_start_count", n_got, 4);
      check("ignored_start_done", n_done - d0, 1);

      // Top of the address space must not wrap
      set_model(20'hFFFFF, 20'hFFFFF, 1'b0);
      rdy_mode = 1;
      kick(20'hFFFFF, 20'hFFFFF, 1'b0);
      addr_zero_seen = 1'b0;
      wait_done(40);
      drain();
      repeat (3) step();
      check("top_count", n_got, 1);
      check("top_no_wrap", addr_zero_seen, 0);

      // Random ranges with random consumer stalls
      for (int r = 0; r < 6; r++) begin
         sa  = ADDR_W'($urandom_range(0, 4095));
         len = $urandom_range(1, 8);
         set_model(sa, sa + ADDR_W'(len - 1), 1'b0);
         rdy_mode = 2; d0 = n_done;
         kick(sa, sa + ADDR_W'(len - 1), 1'b0);
         wait_done(300);
         drain();
         check("rand_count", n_got, len);
         check("rand_done_once", n_done - d0, 1);
      end

      // Reset in the middle of a read
      set_model(20'h00, 20'h03, 1'b0);
      rdy_mode = 0;
      kick(20'h00, 20'h03, 1'b0);
      k = 0;
      while (SRAM_OE_N && k < 10) begin step(); k++; end
      step();
      check("pre_reset_busy", busy, 1);
      reset = 1'b1;
      step();
      check_reset_outputs("midrst");
      reset = 1'b0;
      repeat (3) step();
      check("post_reset_valid", sample_valid, 0);
      check("post_reset_busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
